// File: rtl/calc_pkg.sv
// calc_pkg -- shared types and constants for the calculator input stage.
//   calc_state_t : button debounce FSM states
//   CALC_W       : operand width of the downstream calculator
//   RAW_W        : width of the raw input bundle (a, b, subtract, button)
//   cnt_width()  : counter width able to hold max(debounce, repeat) - 1
package calc_pkg;

  localparam int CALC_W           = 3;
  localparam int RAW_W            = 2 * CALC_W + 2;
  localparam int DEBOUNCE_DEFAULT = 1000000;   // 10 ms at 100 MHz
  localparam int REPEAT_DEFAULT   = 50000000;  // 0.5 s at 100 MHz

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    FIRE,
    HELD,
    RELEASE_WAIT
  } calc_state_t;

  function automatic int cnt_width(input int deb, input int rep);
    int m;
    m = (deb > rep) ? deb : rep;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/calc_input_ctrl_if.sv
// calc_input_ctrl_if -- raw switch/button inputs and conditioned calculator
// outputs of calc_input_ctrl.
//   sw_a, sw_b, sw_subtract, btn_calc : raw asynchronous inputs
//   a, b, subtract                    : operands held for the calculator
//   calc_button                       : one-cycle calculate strobe
//   btn_level                         : debounced button level (LED)
// master: the board / stimulus side.  slave: calc_input_ctrl.
interface calc_input_ctrl_if;
  import calc_pkg::*;

  logic [CALC_W-1:0] sw_a;
  logic [CALC_W-1:0] sw_b;
  logic              sw_subtract;
  logic              btn_calc;
  logic [CALC_W-1:0] a;
  logic [CALC_W-1:0] b;
  logic              subtract;
  logic              calc_button;
  logic              btn_level;

  modport master (
    output sw_a, sw_b, sw_subtract, btn_calc,
    input  a, b, subtract, calc_button, btn_level
  );

  modport slave (
    input  sw_a, sw_b, sw_subtract, btn_calc,
    output a, b, subtract, calc_button, btn_level
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchroniser, W bits wide, async active-high reset to 0.
//   clk, rst : clock / reset
//   d        : asynchronous input
//   q        : input resolved into the clk domain (two-cycle latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl -- input conditioning in front of the 3-bit add/subtract
// calculator. Synchronises the switches and button, debounces the button and
// emits exactly one calc_button pulse per accepted press, with a/b/subtract
// captured on the edge that enters FIRE and held until the next FIRE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : calc_input_ctrl_if.slave (raw inputs in, conditioned outputs)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press or release (>= 2)
//   REPEAT_CYCLES   : auto-repeat period while held
// Build option: define CALC_AUTOREPEAT_EN to re-fire every REPEAT_CYCLES+1
// cycles while the button stays held; otherwise HELD leaves only on release.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  calc_input_ctrl_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef CALC_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // all eight raw inputs share one synchroniser
  logic [RAW_W-1:0]  raw, raw_s;
  logic [CALC_W-1:0] sw_a_s, sw_b_s;
  logic              sw_subtract_s, btn_s;

  assign raw = {bus.btn_calc, bus.sw_subtract, bus.sw_b, bus.sw_a};

  sync_2ff #(.W(RAW_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw),
    .q   (raw_s)
  );

  assign sw_a_s        = raw_s[CALC_W-1:0];
  assign sw_b_s        = raw_s[2*CALC_W-1:CALC_W];
  assign sw_subtract_s = raw_s[2*CALC_W];
  assign btn_s         = raw_s[2*CALC_W+1];

  calc_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [CALC_W-1:0] a_q, b_q;
  logic              sub_q, pulse_q, level_q;

  // Outputs are registered alongside the state: calc_button is set on the
  // edge entering FIRE and cleared on the edge leaving it; btn_level rises
  // entering FIRE and falls only when a release is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state   <= FIRE;
            a_q     <= sw_a_s;
            b_q     <= sw_b_s;
            sub_q   <= sw_subtract_s;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIRE: begin
          state   <= HELD;
          cnt     <= '0;
          pulse_q <= 1'b0;
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef CALC_AUTOREPEAT_EN
          else if (cnt == REP_LAST) begin
            state   <= FIRE;
            a_q     <= sw_a_s;
            b_q     <= sw_b_s;
            sub_q   <= sw_subtract_s;
            pulse_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          // a bounce back high restarts the release debounce from HELD
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= IDLE;
            level_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pulse_q <= 1'b0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.subtract    = sub_q;
  assign bus.calc_button = pulse_q;
  assign bus.btn_level   = level_q;

endmodule
